// File: rtl/pic_dsp_pkg.sv
// Shared definitions for the PIC target-side interrupt dispatcher.
// Holds the per-slot state encoding and the reserved "no interrupt" ID.
// Optional feature macro used by this slice: PIC_DSP_PREEMPT_EN.
package pic_dsp_pkg;

  typedef enum logic [1:0] {
    DSP_IDLE    = 2'b00,
    DSP_PEND    = 2'b01,
    DSP_CLAIMED = 2'b10
  } dsp_state_e;

  // ID 0 is never a real interrupt; it is returned on an empty claim.
  localparam int unsigned DSP_ID_NONE = 0;

endpackage

// File: rtl/pic_dsp_tgt_slot.sv
// One hart-target slot: holds a single pending interrupt, raises the line
// against a live threshold and walks the claim/complete handshake.
// Latency: load shows on o_int_req next cycle; claim response is combinational.
// Macro PIC_DSP_PREEMPT_EN: a PEND slot also reports it can take a higher-priority request.
module pic_dsp_tgt_slot
  import pic_dsp_pkg::*;
#(
  parameter int ID_W   = 10,
  parameter int PRIO_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [ID_W-1:0]   i_id,
  input  logic [PRIO_W-1:0] i_prio,
  input  logic [PRIO_W-1:0] i_thresh,
  input  logic              i_claim,
  input  logic              i_cmplt,
  input  logic [ID_W-1:0]   i_cmplt_id,
  output logic              o_int_req,
  output logic [ID_W-1:0]   o_claim_id,
  output logic              o_idle,
  output logic              o_accept_ok
);

  dsp_state_e          r_state;
  logic [ID_W-1:0]     r_id;
  logic [PRIO_W-1:0]   r_prio;

  logic                w_int_req;
  logic                w_claim_take;
  logic                w_cmplt_hit;

  // Line is live against the threshold so a threshold write acts immediately.
  assign w_int_req    = (r_state == DSP_PEND) && (r_prio > i_thresh);
  assign w_claim_take = i_claim && w_int_req;
  assign w_cmplt_hit  = i_cmplt && (i_cmplt_id == r_id);

  assign o_int_req  = w_int_req;
  assign o_claim_id = w_claim_take ? r_id : ID_W'(DSP_ID_NONE);
  assign o_idle     = (r_state == DSP_IDLE);

  // Whether this slot could take the current arbitration winner (claim gating is done by the caller).
  always_comb begin
    o_accept_ok = (r_state == DSP_IDLE);
`ifdef PIC_DSP_PREEMPT_EN
    if ((r_state == DSP_PEND) && (i_prio > r_prio)) begin
      o_accept_ok = 1'b1;
    end
`endif
  end

  // Slot FSM with its ID and priority registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= DSP_IDLE;
      r_id    <= '0;
      r_prio  <= '0;
    end else begin
      case (r_state)
        DSP_IDLE: begin
          if (i_load) begin
            r_state <= DSP_PEND;
            r_id    <= i_id;
            r_prio  <= i_prio;
          end
        end
        DSP_PEND: begin
          if (w_claim_take) begin
            r_state <= DSP_CLAIMED;
          end else if (i_load) begin
            // Preempting load: the displaced ID stays pending at its gateway.
            r_id   <= i_id;
            r_prio <= i_prio;
          end
        end
        DSP_CLAIMED: begin
          if (w_cmplt_hit) begin
            r_state <= DSP_IDLE;
          end
        end
        default: begin
          r_state <= DSP_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/pic_int_dispatch.sv
// Steers the single arbitration winner to one of TGT_NUM hart-target slots.
// Latency: accepted request raises tgt_int_req next cycle; claims answer combinationally.
// Backpressure: arb_req_rdy low when the addressed slot is busy or claimed this cycle.
// Macro PIC_DSP_PREEMPT_EN: a pending slot can be overwritten by a strictly higher priority.
module pic_int_dispatch
  import pic_dsp_pkg::*;
#(
  parameter int TGT_NUM = 4,
  parameter int ID_W    = 10,
  parameter int PRIO_W  = 5,
  parameter int TGT_W   = $clog2(TGT_NUM)
) (
  input  logic                      pic_clk,
  input  logic                      pic_rst_b,
  input  logic                      arb_req_vld,
  input  logic [ID_W-1:0]           arb_req_id,
  input  logic [PRIO_W-1:0]         arb_req_prio,
  input  logic [TGT_W-1:0]          arb_req_tgt,
  output logic                      arb_req_rdy,
  input  logic [TGT_NUM*PRIO_W-1:0] tgt_thresh,
  output logic [TGT_NUM-1:0]        tgt_int_req,
  input  logic [TGT_NUM-1:0]        tgt_claim_vld,
  output logic [TGT_NUM*ID_W-1:0]   tgt_claim_id,
  input  logic [TGT_NUM-1:0]        tgt_cmplt_vld,
  input  logic [TGT_NUM*ID_W-1:0]   tgt_cmplt_id,
  output logic                      dsp_busy
);

  logic [TGT_NUM-1:0] w_idle;
  logic [TGT_NUM-1:0] w_accept_ok;
  logic [TGT_NUM-1:0] w_can_take;
  logic [TGT_NUM-1:0] w_load;

  // A claim on the addressed slot always wins over a new request in that cycle.
  assign w_can_take = w_accept_ok & ~tgt_claim_vld;

  // Decode the target index; indices past TGT_NUM match no slot and read not-ready.
  always_comb begin
    arb_req_rdy = 1'b0;
    w_load      = '0;
    for (int t = 0; t < TGT_NUM; t++) begin
      if (arb_req_tgt == TGT_W'(t)) begin
        arb_req_rdy = w_can_take[t];
        w_load[t]   = arb_req_vld && w_can_take[t];
      end
    end
  end

  assign dsp_busy = ~(&w_idle);

  for (genvar g = 0; g < TGT_NUM; g++) begin : g_slot
    pic_dsp_tgt_slot #(
      .ID_W   (ID_W),
      .PRIO_W (PRIO_W)
    ) u_slot (
      .i_clk       (pic_clk),
      .i_rst_n     (pic_rst_b),
      .i_load      (w_load[g]),
      .i_id        (arb_req_id),
      .i_prio      (arb_req_prio),
      .i_thresh    (tgt_thresh[g*PRIO_W +: PRIO_W]),
      .i_claim     (tgt_claim_vld[g]),
      .i_cmplt     (tgt_cmplt_vld[g]),
      .i_cmplt_id  (tgt_cmplt_id[g*ID_W +: ID_W]),
      .o_int_req   (tgt_int_req[g]),
      .o_claim_id  (tgt_claim_id[g*ID_W +: ID_W]),
      .o_idle      (w_idle[g]),
      .o_accept_ok (w_accept_ok[g])
    );
  end

endmodule

// File: tb/tb_pic_int_dispatch.sv
// Self-checking bench for pic_int_dispatch: directed scenarios with literal
// expectations, then randomized traffic against a per-target behavioural model.
// Optional feature macro: PIC_DSP_PREEMPT_EN.
module tb_pic_int_dispatch;

  localparam int TGT_NUM = 4;
  localparam int ID_W    = 10;
  localparam int PRIO_W  = 5;
  localparam int TGT_W   = 2;
`ifdef PIC_DSP_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic                      pic_clk = 1'b0;
  logic                      pic_rst_b;
  logic                      arb_req_vld;
  logic [ID_W-1:0]           arb_req_id;
  logic [PRIO_W-1:0]         arb_req_prio;
  logic [TGT_W-1:0]          arb_req_tgt;
  logic                      arb_req_rdy;
  logic [TGT_NUM*PRIO_W-1:0] tgt_thresh;
  logic [TGT_NUM-1:0]        tgt_int_req;
  logic [TGT_NUM-1:0]        tgt_claim_vld;
  logic [TGT_NUM*ID_W-1:0]   tgt_claim_id;
  logic [TGT_NUM-1:0]        tgt_cmplt_vld;
  logic [TGT_NUM*ID_W-1:0]   tgt_cmplt_id;
  logic                      dsp_busy;

  pic_int_dispatch #(
    .TGT_NUM (TGT_NUM),
    .ID_W    (ID_W),
    .PRIO_W  (PRIO_W),
    .TGT_W   (TGT_W)
  ) dut (
    .pic_clk       (pic_clk),
    .pic_rst_b     (pic_rst_b),
    .arb_req_vld   (arb_req_vld),
    .arb_req_id    (arb_req_id),
    .arb_req_prio  (arb_req_prio),
    .arb_req_tgt   (arb_req_tgt),
    .arb_req_rdy   (arb_req_rdy),
    .tgt_thresh    (tgt_thresh),
    .tgt_int_req   (tgt_int_req),
    .tgt_claim_vld (tgt_claim_vld),
    .tgt_claim_id  (tgt_claim_id),
    .tgt_cmplt_vld (tgt_cmplt_vld),
    .tgt_cmplt_id  (tgt_cmplt_id),
    .dsp_busy      (dsp_busy)
  );

  always #5 pic_clk = ~pic_clk;

  // Model: each target either holds nothing, a pending interrupt or a claimed one.
  bit              m_pend [TGT_NUM];
  bit              m_clmd [TGT_NUM];
  logic [ID_W-1:0] m_id   [TGT_NUM];
  logic [PRIO_W-1:0] m_prio [TGT_NUM];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PRIO_W-1:0] thr(input int t);
    return tgt_thresh[t*PRIO_W +: PRIO_W];
  endfunction

  function automatic logic [ID_W-1:0] claim_out(input int t);
    return tgt_claim_id[t*ID_W +: ID_W];
  endfunction

  function automatic bit exp_line(input int t);
    return m_pend[t] && (m_prio[t] > thr(t));
  endfunction

  function automatic bit exp_rdy();
    int t;
    t = int'(arb_req_tgt);
    if (t >= TGT_NUM) return 1'b0;
    if (tgt_claim_vld[t]) return 1'b0;
    if (!m_pend[t] && !m_clmd[t]) return 1'b1;
    return PREEMPT && m_pend[t] && (arb_req_prio > m_prio[t]);
  endfunction

  task automatic model_clear();
    for (int t = 0; t < TGT_NUM; t++) begin
      m_pend[t] = 1'b0;
      m_clmd[t] = 1'b0;
      m_id[t]   = '0;
      m_prio[t] = '0;
    end
  endtask

  // Compare all outputs against the model near the falling edge.
  task automatic model_check();
    logic [TGT_NUM-1:0] req;
    bit busy;
    #4;
    busy = 1'b0;
    for (int t = 0; t < TGT_NUM; t++) begin
      req[t] = exp_line(t);
      if (m_pend[t] || m_clmd[t]) busy = 1'b1;
    end
    chk("int_req", 64'(tgt_int_req), 64'(req));
    chk("rdy", 64'(arb_req_rdy), 64'(exp_rdy()));
    chk("busy", 64'(dsp_busy), 64'(busy));
    for (int t = 0; t < TGT_NUM; t++) begin
      if (tgt_claim_vld[t]) begin
        chk($sformatf("claim_id[%0d]", t), 64'(claim_out(t)),
            64'(req[t] ? m_id[t] : '0));
      end
    end
  endtask

  // Apply the clock edge to the model, then step to just after the DUT edge.
  task automatic advance();
    bit acc;
    int at;
    acc = arb_req_vld && exp_rdy();
    at  = int'(arb_req_tgt);
    for (int t = 0; t < TGT_NUM; t++) begin
      if (tgt_claim_vld[t] && exp_line(t)) begin
        m_pend[t] = 1'b0;
        m_clmd[t] = 1'b1;
      end else if (m_clmd[t] && tgt_cmplt_vld[t] &&
                   tgt_cmplt_id[t*ID_W +: ID_W] == m_id[t]) begin
        m_clmd[t] = 1'b0;
      end
    end
    if (acc) begin
      m_pend[at] = 1'b1;
      m_id[at]   = arb_req_id;
      m_prio[at] = arb_req_prio;
    end
    @(posedge pic_clk);
    #1;
  endtask

  task automatic idle_in();
    arb_req_vld   = 1'b0;
    arb_req_id    = '0;
    arb_req_prio  = '0;
    arb_req_tgt   = '0;
    tgt_claim_vld = '0;
    tgt_cmplt_vld = '0;
    tgt_cmplt_id  = '0;
  endtask

  task automatic req(input int id, input int prio, input int tgt);
    idle_in();
    arb_req_vld  = 1'b1;
    arb_req_id   = ID_W'(id);
    arb_req_prio = PRIO_W'(prio);
    arb_req_tgt  = TGT_W'(tgt);
  endtask

  task automatic cmplt(input int tgt, input int id);
    idle_in();
    tgt_cmplt_vld[tgt] = 1'b1;
    tgt_cmplt_id[tgt*ID_W +: ID_W] = ID_W'(id);
  endtask

  task automatic do_reset();
    idle_in();
    pic_rst_b = 1'b0;
    model_clear();
    #3;
    @(negedge pic_clk);
    pic_rst_b = 1'b1;
    @(posedge pic_clk);
    #1;
  endtask

  int exp_claim;

  initial begin
    pic_rst_b  = 1'b0;
    tgt_thresh = '0;
    idle_in();
    model_clear();
    #3;
    chk("rst_int_req", 64'(tgt_int_req), 64'h0);
    chk("rst_claim_id", 64'(tgt_claim_id), 64'h0);
    chk("rst_rdy", 64'(arb_req_rdy), 64'h1);
    chk("rst_busy", 64'(dsp_busy), 64'h0);
    @(negedge pic_clk);
    pic_rst_b = 1'b1;
    @(posedge pic_clk);
    #1;

    // Basic accept / raise / claim / complete on target 1.
    req(5, 3, 1);                 model_check(); chk("lit_rdy_t1", 64'(arb_req_rdy), 64'h1); advance();
    idle_in();                    model_check(); chk("lit_line_t1", 64'(tgt_int_req), 64'h2); advance();
    idle_in(); tgt_claim_vld[1] = 1'b1;
                                  model_check(); chk("lit_claim5", 64'(claim_out(1)), 64'd5); advance();
    cmplt(1, 6);                  model_check(); chk("lit_line_drop", 64'(tgt_int_req), 64'h0); advance();
    cmplt(1, 5);                  model_check(); chk("lit_busy_cl", 64'(dsp_busy), 64'h1); advance();
    idle_in();                    model_check(); chk("lit_busy_idle", 64'(dsp_busy), 64'h0);
                                  chk("lit_rdy_again", 64'(arb_req_rdy), 64'h1); advance();

    // Threshold: equal priority does not raise the line; lowering it does immediately.
    tgt_thresh[0 +: PRIO_W] = PRIO_W'(2);
    req(7, 2, 0);                 model_check(); advance();
    idle_in(); tgt_claim_vld[0] = 1'b1;
                                  model_check(); chk("lit_line_eq", 64'(tgt_int_req[0]), 64'h0);
                                  chk("lit_claim_none", 64'(claim_out(0)), 64'h0); advance();
    idle_in(); tgt_thresh[0 +: PRIO_W] = PRIO_W'(1);
                                  model_check(); chk("lit_line_thr", 64'(tgt_int_req[0]), 64'h1); advance();
    idle_in(); tgt_claim_vld[0] = 1'b1;
                                  model_check(); chk("lit_claim7", 64'(claim_out(0)), 64'd7); advance();
    cmplt(0, 7);                  model_check(); advance();

    // Busy slot: higher priority only displaces under preemption; equal never does.
    req(9, 4, 2);                 model_check(); advance();
    req(12, 4, 2);                model_check(); chk("lit_rdy_eq", 64'(arb_req_rdy), 64'h0); advance();
    req(11, 6, 2);                model_check(); chk("lit_rdy_pre", 64'(arb_req_rdy), 64'(PREEMPT)); advance();
    exp_claim = PREEMPT ? 11 : 9;
    idle_in(); tgt_claim_vld[2] = 1'b1;
                                  model_check(); chk("lit_claim_pre", 64'(claim_out(2)), 64'(exp_claim)); advance();
    cmplt(2, exp_claim);          model_check(); advance();

    // Request plus claim on the same target: the claim wins, old ID returned.
    req(9, 4, 2);                 model_check(); advance();
    req(11, 6, 2); tgt_claim_vld[2] = 1'b1;
                                  model_check(); chk("lit_rdy_clm", 64'(arb_req_rdy), 64'h0);
                                  chk("lit_claim_old", 64'(claim_out(2)), 64'd9); advance();
    cmplt(2, 9);                  model_check(); advance();

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      idle_in();
      arb_req_vld  = ($urandom % 2) == 0;
      arb_req_id   = ID_W'($urandom_range(1, (1 << ID_W) - 1));
      arb_req_prio = PRIO_W'($urandom % 8);
      arb_req_tgt  = TGT_W'($urandom % TGT_NUM);
      tgt_claim_vld = TGT_NUM'($urandom & $urandom);
      tgt_cmplt_vld = TGT_NUM'($urandom & $urandom);
      for (int t = 0; t < TGT_NUM; t++) begin
        if (($urandom % 4) != 0) tgt_cmplt_id[t*ID_W +: ID_W] = m_id[t];
        else tgt_cmplt_id[t*ID_W +: ID_W] = ID_W'($urandom);
        if (($urandom % 8) == 0) tgt_thresh[t*PRIO_W +: PRIO_W] = PRIO_W'($urandom % 8);
      end
      model_check();
      advance();
    end

    // Asynchronous reset while targets 0 and 3 are claimed.
    tgt_thresh = '0;
    do_reset();
    req(20, 5, 0);                model_check(); advance();
    req(21, 5, 3);                model_check(); advance();
    idle_in(); tgt_claim_vld = 4'b1001;
                                  model_check(); advance();
    idle_in();                    model_check(); chk("lit_busy_pre_rst", 64'(dsp_busy), 64'h1);
    #2;
    pic_rst_b = 1'b0;
    #1;
    model_clear();
    chk("arst_int_req", 64'(tgt_int_req), 64'h0);
    chk("arst_busy", 64'(dsp_busy), 64'h0);
    chk("arst_claim_id", 64'(tgt_claim_id), 64'h0);
    #1;
    pic_rst_b = 1'b1;
    @(posedge pic_clk);
    #1;
    req(30, 5, 3);                model_check(); chk("lit_rdy_post_rst", 64'(arb_req_rdy), 64'h1); advance();
    idle_in();                    model_check(); chk("lit_line_post_rst", 64'(tgt_int_req), 64'h8); advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pic_int_dispatch.md
# pic_int_dispatch

Interrupt dispatcher on the target side of the PIC: it takes the single arbitration winner each cycle and steers it to one of TGT_NUM hart-target slots. Each slot holds one pending interrupt, raises that hart's interrupt line against its priority threshold, and runs the claim/complete handshake back to idle. It is the demultiplexing counterpart of the source-select mux tree that feeds the arbiter.

## Interface
- TGT_NUM, 4: number of hart targets (2..16)
- ID_W, 10: interrupt ID width; ID 0 means "no interrupt"
- PRIO_W, 5: priority width
- TGT_W, $clog2(TGT_NUM): target index width
- pic_clk  in  1  single block clock
- pic_rst_b  in  1  reset, asynchronous assert, active-low
- arb_req_vld  in  1  arbitration winner valid
- arb_req_id  in  ID_W  winner ID, nonzero when arb_req_vld
- arb_req_prio  in  PRIO_W  winner priority
- arb_req_tgt  in  TGT_W  destination target index
- arb_req_rdy  out  1  winner accepted this cycle when high with arb_req_vld
- tgt_thresh  in  TGT_NUM*PRIO_W  per-target threshold, slice t for target t
- tgt_int_req  out  TGT_NUM  interrupt line per hart
- tgt_claim_vld  in  TGT_NUM  one-cycle claim pulse per target
- tgt_claim_id  out  TGT_NUM*ID_W  claim response, valid in the claim cycle
- tgt_cmplt_vld  in  TGT_NUM  one-cycle complete pulse per target
- tgt_cmplt_id  in  TGT_NUM*ID_W  completed ID
- dsp_busy  out  1  any slot not IDLE

## Operation
- Each slot has a 2-bit FSM (IDLE, PEND, CLAIMED) plus id_q[ID_W] and prio_q[PRIO_W].
- IDLE -> PEND: arb_req_vld && arb_req_tgt==t && slot IDLE. Loads id and prio.
- arb_req_rdy is combinational: the addressed slot is IDLE and its claim input is low. arb_req_tgt >= TGT_NUM gives rdy=0.
- tgt_int_req[t] = (state==PEND) && (prio_q > tgt_thresh[t]). The compare is unsigned and strict. The threshold is sampled live.
- Claim while tgt_int_req[t]=1: tgt_claim_id = id_q and the slot moves PEND -> CLAIMED.
- Claim while tgt_int_req[t]=0 (IDLE, PEND below threshold, or CLAIMED): tgt_claim_id = 0 and the state does not change.
- CLAIMED -> IDLE: tgt_cmplt_vld[t] && tgt_cmplt_id == id_q.
- A mismatched complete, or a complete in any other state, is ignored.
- Slots are independent. Several targets may claim or complete in the same cycle.
- Reset (asynchronous, mid-operation included): all slots go to IDLE, id_q and prio_q clear to 0. Outputs then read: tgt_int_req=0, tgt_claim_id=0, arb_req_rdy=1 for a valid target index, dsp_busy=0.

## Timing
- A request accepted at edge k gives tgt_int_req high in cycle k+1, when above threshold.
- Claim response is zero-latency (combinational from id_q). tgt_int_req drops in the cycle after the claim edge.
- Complete at edge k: the slot is IDLE in k+1, and a new request to that target can be accepted in k+1.
- Same cycle, same target: a claim blocks acceptance. A complete in CLAIMED does not make rdy high in that cycle, so there is no bypass.
- A threshold change takes effect on tgt_int_req in the same cycle.

## Configuration
- PIC_DSP_PREEMPT_EN defined: a slot in PEND also accepts a request whose arb_req_prio > prio_q, provided there is no claim that cycle. id_q and prio_q are overwritten and the displaced ID is dropped, because the gateway keeps it pending and it is re-arbitrated.
- Equal priority never preempts.
- PIC_DSP_PREEMPT_EN undefined: a slot accepts only in IDLE.

## Structure
- Package pic_dsp_pkg holds:
  - state encodings: IDLE=2'b00, PEND=2'b01, CLAIMED=2'b10
  - the ID-0 "none" constant
- Sub-module pic_dsp_tgt_slot holds one slot's FSM, registers, threshold compare and claim mux. The top instantiates it TGT_NUM times in a generate loop and builds arb_req_rdy, the per-slot load enables and dsp_busy.

## Test plan
- Reset, then request id=5 prio=3 tgt=1 with thresh[1]=0 -> rdy=1; tgt_int_req[1]=1 next cycle; other lines stay 0.
- Claim tgt 1 -> tgt_claim_id[1]=5 in the same cycle; int_req[1]=0 next cycle. Complete with id 6 -> ignored, slot stays CLAIMED. Complete with id 5 -> IDLE next cycle.
- Pend id=7 prio=2 with thresh=2 -> int_req=0 and a claim returns 0. Set thresh=1 -> int_req=1 in the same cycle.
- Slot 2 in PEND with id=9 prio=4; new request id=11 prio=6 to tgt 2 -> rdy=0 without PIC_DSP_PREEMPT_EN. With it: rdy=1 and a claim returns 11.
- With PIC_DSP_PREEMPT_EN, a request and a claim to the same target in the same cycle -> rdy=0 and claim returns the old ID.
- Reset asserted while slots 0 and 3 are CLAIMED -> all tgt_int_req=0, dsp_busy=0 asynchronously; accept works in the first cycle after release.
